// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, mthilo selects,
// FSM states and the latency counter width.
package muldiv_pkg;

  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MADD  = 3'd5,
    OP_MSUB  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  localparam logic [1:0] MTHILO_NONE = 2'b00;
  localparam logic [1:0] MTHILO_LO   = 2'b01;
  localparam logic [1:0] MTHILO_HI   = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/muldiv_divider.sv
// Combinational signed/unsigned divide: quotient truncates toward zero, remainder
// takes the dividend's sign; a zero divisor is flagged and its outputs are don't-care.
module muldiv_divider #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] b_safe;
  logic [WIDTH-1:0] q_u;
  logic [WIDTH-1:0] r_u;

  assign neg_a    = is_signed & dividend[WIDTH-1];
  assign neg_b    = is_signed & divisor[WIDTH-1];
  assign a_abs    = neg_a ? -dividend : dividend;
  assign b_abs    = neg_b ? -divisor : divisor;
  assign div_zero = (divisor == '0);
  // Substitute 1 for a zero divisor so the operator never sees x/0.
  assign b_safe   = div_zero ? WIDTH'(1) : b_abs;
  assign q_u      = a_abs / b_safe;
  assign r_u      = a_abs % b_safe;
  // MIN / -1 wraps back to MIN through the negation, which is the wanted result.
  assign quo      = (neg_a ^ neg_b) ? -q_u : q_u;
  assign rem      = neg_a ? -r_u : r_u;

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/MADD/MSUB (and DIV/DIVU when MULDIV_DIV_EN is defined) unit; busy for
// MUL_CYCLES/DIV_CYCLES after start, results commit as busy falls, start/mthilo ignored while busy.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [1:0]       mthilo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int DW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] cnt;
  op_e              op_in;
  op_e              op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             op_ok;
  logic             launch;
  logic             finish;
  logic [DW-1:0]    a_sx;
  logic [DW-1:0]    b_sx;
  logic [DW-1:0]    prod_s;
  logic [DW-1:0]    prod_u;
  logic [DW-1:0]    hilo;
  logic [DW-1:0]    res;
  logic             res_wr;

  assign op_in = op_e'(op);

  always_comb begin
    op_ok = 1'b0;
    case (op_in)
      OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: op_ok = 1'b1;
`ifdef MULDIV_DIV_EN
      OP_DIV, OP_DIVU:                     op_ok = 1'b1;
`endif
      default:                             op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    finish    = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && op_ok) begin
          launch    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == '0) begin
          finish    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Multiplies are computed from the latched operands; the counter only models latency.
  assign a_sx   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign b_sx   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  assign hilo   = {hi, lo};

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             div_zero;

  muldiv_divider #(.WIDTH(WIDTH)) u_divider (
    .dividend (a_q),
    .divisor  (b_q),
    .is_signed(op_q == OP_DIV),
    .quo      (quo),
    .rem      (rem),
    .div_zero (div_zero)
  );
`endif

  always_comb begin
    res    = prod_s;
    res_wr = 1'b1;
    case (op_q)
      OP_MULTU: res = prod_u;
      OP_MADD:  res = hilo + prod_s;
      OP_MSUB:  res = hilo - prod_s;
`ifdef MULDIV_DIV_EN
      OP_DIV, OP_DIVU: begin
        res    = {rem, quo};
        res_wr = ~div_zero;
      end
`endif
      default:  res = prod_s;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      op_q <= OP_NONE;
      a_q  <= '0;
      b_q  <= '0;
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= finish;
      if (launch) begin
        op_q <= op_in;
        a_q  <= src_a;
        b_q  <= src_b;
        cnt  <= (op_in == OP_DIV || op_in == OP_DIVU) ? DIV_LOAD : MUL_LOAD;
      end else if (busy && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      // A launching start takes priority over a same-cycle mthilo write.
      if (finish && res_wr) begin
        {hi, lo} <= res;
      end else if (state == S_IDLE && !launch) begin
        case (mthilo)
          MTHILO_LO: lo <= src_a;
          MTHILO_HI: hi <= src_a;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH 32, MUL_CYCLES 5, DIV_CYCLES 10.
module tb_muldiv_unit;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        start  = 1'b0;
  logic [2:0]  op     = 3'd0;
  logic [31:0] src_a  = '0;
  logic [31:0] src_b  = '0;
  logic [1:0]  mthilo = 2'b00;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .mthilo(mthilo),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Launch one op, optionally poke a second start mid-run, and watch a fixed window.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, output int nbusy, output int ndone,
                        output logic [63:0] mid);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    nbusy = 0; ndone = 0; mid = '0;
    for (int i = 0; i < 14; i++) begin
      if (busy) nbusy++;
      if (done) ndone++;
      if (i == 2) mid = {hi, lo};
      if (inject && i == 1) begin start = 1'b1; op = 3'd1; src_a = 32'd0; src_b = 32'd0; end
      if (inject && i == 2) begin start = 1'b0; op = 3'd0; end
      @(negedge clk);
    end
  endtask

  task automatic set_hilo(input logic [1:0] sel, input logic [31:0] val);
    @(negedge clk);
    mthilo = sel; src_a = val;
    @(negedge clk);
    mthilo = 2'b00;
  endtask

  initial begin
    int nb;
    int nd;
    logic [63:0] mid;

    repeat (2) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;

    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, nb, nd, mid);
    check("mult_busy_cycles", 64'(nb), 64'd5);
    check("mult_done_pulses", 64'(nd), 64'd1);
    check("mult_hold_in_run", mid, 64'd0);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);

    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, nb, nd, mid);
    check("multu_busy_cycles", 64'(nb), 64'd5);
    check("multu_done_pulses", 64'(nd), 64'd1);
    check("multu_hold_in_run", mid, 64'hFFFF_FFFF_FFFF_FFFE);
    check("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

    set_hilo(2'b10, 32'h1234_5678);
    check("mthi", {32'd0, hi}, 64'h0000_0000_1234_5678);
    set_hilo(2'b01, 32'h0000_0000);
    check("mtlo", {32'd0, lo}, 64'd0);
    set_hilo(2'b11, 32'hDEAD_BEEF);
    check("mthilo_11_nowrite", {hi, lo}, 64'h1234_5678_0000_0000);
    run_op(3'd5, 32'd3, 32'd4, 1'b0, nb, nd, mid);
    check("madd_busy_cycles", 64'(nb), 64'd5);
    check("madd_hilo", {hi, lo}, 64'h1234_5678_0000_000C);

    set_hilo(2'b10, 32'd0);
    set_hilo(2'b01, 32'd0);
    run_op(3'd6, 32'd1, 32'd1, 1'b0, nb, nd, mid);
    check("msub_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);

    run_op(3'd5, 32'hFFFF_FFFE, 32'd3, 1'b0, nb, nd, mid);
    check("madd_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF9);

    run_op(3'd0, 32'd9, 32'd9, 1'b0, nb, nd, mid);
    check("op0_busy", 64'(nb), 64'd0);
    check("op0_done", 64'(nd), 64'd0);
    run_op(3'd7, 32'd9, 32'd9, 1'b0, nb, nd, mid);
    check("op7_busy", 64'(nb), 64'd0);
    check("op7_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF9);

    @(negedge clk);
    start = 1'b1; op = 3'd1; src_a = 32'd2; src_b = 32'd3; mthilo = 2'b01;
    @(negedge clk);
    start = 1'b0; op = 3'd0; mthilo = 2'b00;
    check("start_wins_busy", {63'd0, busy}, 64'd1);
    check("start_wins_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFF9);
    repeat (6) @(negedge clk);
    check("start_wins_hilo", {hi, lo}, 64'h0000_0000_0000_0006);

    @(negedge clk);
    start = 1'b1; op = 3'd1; src_a = 32'd5; src_b = 32'd5;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_run_busy", {63'd0, busy}, 64'd0);
    check("rst_run_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0; nb = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) nd++;
      if (busy) nb++;
      @(negedge clk);
    end
    check("rst_run_no_done", 64'(nd), 64'd0);
    check("rst_run_no_busy", 64'(nb), 64'd0);
    check("rst_run_no_commit", {hi, lo}, 64'd0);

`ifdef MULDIV_DIV_EN
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, nb, nd, mid);
    check("div_busy_cycles", 64'(nb), 64'd10);
    check("div_done_pulses", 64'(nd), 64'd1);
    check("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd3, 32'd5, 32'd0, 1'b0, nb, nd, mid);
    check("div0_busy_cycles", 64'(nb), 64'd10);
    check("div0_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, nb, nd, mid);
    check("div_min_neg1", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, nb, nd, mid);
    check("divu_hilo", {hi, lo}, 64'h0000_0001_7FFF_FFFC);
`else
    set_hilo(2'b10, 32'h5A5A_5A5A);
    run_op(3'd4, 32'd7, 32'd2, 1'b0, nb, nd, mid);
    check("nodiv_divu_busy", 64'(nb), 64'd0);
    check("nodiv_divu_done", 64'(nd), 64'd0);
    check("nodiv_divu_hilo", {hi, lo}, 64'h5A5A_5A5A_0000_0000);
    run_op(3'd3, 32'd7, 32'd2, 1'b0, nb, nd, mid);
    check("nodiv_div_busy", 64'(nb), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 SHALL have parameter MUL_CYCLES, default 5, multiply/MADD/MSUB busy duration (legal 1..63).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, divide busy duration (legal 1..63).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  launch the operation on op, sampled on the clk rising edge.
REQ-007 SHALL have port op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MSUB, 7 reserved.
REQ-008 SHALL have port src_a  input  WIDTH  first operand (rs).
REQ-009 SHALL have port src_b  input  WIDTH  second operand (rt).
REQ-010 SHALL have port mthilo  input  2  01 write src_a to LO, 10 write src_a to HI, 00/11 no write.
REQ-011 SHALL have port busy  output  1  operation in flight.
REQ-012 SHALL have port done  output  1  one-cycle pulse on the cycle after commit.
REQ-013 SHALL have ports hi and lo  output  WIDTH  architectural HI/LO registers.

Function
REQ-014 SHALL implement FSM states IDLE and RUN with a 6-bit down-counter.
REQ-015 In IDLE, start with op 1..6 SHALL latch the operands and op, load the counter with N-1 (N = MUL_CYCLES or DIV_CYCLES), and enter RUN.
REQ-016 busy SHALL be high for exactly N cycles beginning the cycle after start. On the edge that ends RUN, hi/lo SHALL update and busy SHALL fall.
REQ-017 start with op 0 or 7 SHALL be ignored. start while in RUN SHALL be ignored.
REQ-018 MULT/MULTU SHALL produce a 2*WIDTH signed/unsigned product: {hi,lo} = product.
REQ-019 MADD/MSUB SHALL compute {hi,lo} = {hi,lo} +/- the signed product, mod 2^(2*WIDTH), using the hi/lo values at commit time.
REQ-020 DIV/DIVU SHALL give lo = quotient truncated toward zero and hi = remainder with the sign of the dividend.
REQ-021 Divide by zero SHALL consume DIV_CYCLES and leave hi/lo unchanged.
REQ-022 DIV of the most negative value by -1 SHALL give lo = most negative value, hi = 0.
REQ-023 mthilo in IDLE SHALL write hi or lo at the next edge. mthilo in RUN SHALL be ignored; the hazard logic stalls.
REQ-024 If start and mthilo are both asserted in IDLE, start SHALL win and the mthilo write SHALL be dropped.
REQ-025 hi/lo SHALL hold their old values during RUN. The new values SHALL be visible the cycle busy is low.

Reset
REQ-026 reset SHALL asynchronously force IDLE, counter 0, busy 0, done 0, hi 0, lo 0.
REQ-027 reset during RUN SHALL abort the operation with no commit and no done pulse.

Configuration
REQ-028 With macro MULDIV_DIV_EN defined, DIV/DIVU SHALL behave as specified above.
REQ-029 Without MULDIV_DIV_EN, no divider logic SHALL be present, and op 3/4 SHALL be treated as NONE (ignored, busy stays 0).

Structure
REQ-030 A shared package muldiv_pkg SHALL hold the op encodings, the mthilo encodings, the FSM state enum, and counter width 6.
REQ-031 A single sub-module muldiv_divider (combinational signed/unsigned quotient/remainder) SHALL be instantiated only under MULDIV_DIV_EN.
REQ-032 The multiply path SHALL stay inline. The counter SHALL model latency only.

Verification
REQ-033 Directed scenarios (WIDTH 32, MUL_CYCLES 5, DIV_CYCLES 10):
- MULT src_a=0xFFFFFFFF, src_b=2 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulses once.
- MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE. A second start during busy is ignored.
- DIV src_a=-7, src_b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV by 0 -> hi/lo unchanged.
- mthilo=10 with src_a=0x12345678, then MADD 3*4 -> hi=0x12345678, lo=0x0000000C. MSUB 1*1 from hi=lo=0 -> hi=lo=0xFFFFFFFF.
- Assert reset at RUN cycle 3 -> busy=0, hi=lo=0 immediately, no done. mthilo together with start -> mthilo dropped.
- Build without MULDIV_DIV_EN: DIVU start -> busy stays 0, hi/lo unchanged.
